// File: rtl/program_loader.sv
// Framed byte-stream boot loader: assembles 20-bit words into instruction
// memory from address 0 and releases the core only after a verified load.
module program_loader #(
  parameter int INSTR_WIDTH    = 20,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HEADER,
    S_BYTE0,
    S_BYTE1,
    S_BYTE2,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [7:0]    idx, idx_n;
  logic [7:0]    num, num_n;
  logic [7:0]    csum, csum_n;
  logic [7:0]    b0, b0_n;
  logic [7:0]    b1, b1_n;
  logic          accept;
  logic          t_hit;
  logic          recv_n;

  assign accept = rx_valid && rx_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    num_n   = num;
    csum_n  = csum;
    b0_n    = b0;
    b1_n    = b1;
    t_hit   = 1'b0;

    // An accepted byte on the limit cycle wins over the timeout.
    if (TIMEOUT_CYCLES > 0 && rx_ready && !accept) begin
      if (cnt == TW'(TIMEOUT_CYCLES - 1))
        t_hit = 1'b1;
      else
        cnt_n = cnt + TW'(1);
    end
    if (accept) begin
      cnt_n  = '0;
      csum_n = csum ^ rx_data;
    end

    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_n = S_HEADER;
          cnt_n   = '0;
          idx_n   = '0;
          csum_n  = '0;
        end
      end
      S_HEADER: begin
        if (accept) begin
          num_n   = rx_data;
          state_n = (rx_data == 8'd0) ? S_CHECK : S_BYTE0;
        end
      end
      S_BYTE0: begin
        if (accept) begin
          b0_n    = rx_data;
          state_n = S_BYTE1;
        end
      end
      S_BYTE1: begin
        if (accept) begin
          b1_n    = rx_data;
          state_n = S_BYTE2;
        end
      end
      S_BYTE2: begin
        if (accept)
          state_n = (rx_data[7:4] != 4'h0) ? S_ERROR : S_WRITE;
      end
      S_WRITE: begin
        idx_n   = idx + 8'd1;
        state_n = (idx == num - 8'd1) ? S_CHECK : S_BYTE0;
      end
      S_CHECK: begin
        if (accept)
          state_n = (rx_data == csum) ? S_DONE : S_ERROR;
      end
      default: state_n = S_IDLE;
    endcase

    if (t_hit)
      state_n = S_ERROR;

    recv_n = (state_n == S_HEADER) || (state_n == S_BYTE0) ||
             (state_n == S_BYTE1)  || (state_n == S_BYTE2) ||
             (state_n == S_CHECK);
  end

  // Outputs are decoded from the next state so they are pure flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      num       <= '0;
      csum      <= '0;
      b0        <= '0;
      b1        <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      num      <= num_n;
      csum     <= csum_n;
      b0       <= b0_n;
      b1       <= b1_n;
      rx_ready <= recv_n;
      busy     <= recv_n || (state_n == S_WRITE);
      mem_we   <= (state_n == S_WRITE);
      if (state == S_BYTE2 && state_n == S_WRITE) begin
        mem_addr  <= ADDR_WIDTH'(idx);
        mem_wdata <= INSTR_WIDTH'({rx_data[3:0], b1, b0});
      end
      cpu_rst  <= (state_n != S_DONE);
      done     <= (state_n == S_DONE);
      error    <= (state_n == S_ERROR);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: fixed frames, timeout edges, reset and
// randomized frames checked against a frame-level parsing model.
module tb_program_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [19:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  got_addr[$];
  logic [19:0] got_data[$];
  logic [7:0]  exp_addr[$];
  logic [19:0] exp_data[$];
  bit          exp_ok;
  int          exp_used;

  always #5 clk = ~clk;

  program_loader #(
    .INSTR_WIDTH(20),
    .ADDR_WIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Parse a frame the way the loader should: words, reserved check, xor.
  task automatic model(input bq_t b);
    logic [7:0] n, x, c0, c1, c2;
    int pos;
    exp_addr.delete();
    exp_data.delete();
    n = b[0];
    x = n;
    pos = 1;
    for (int w = 0; w < int'(n); w++) begin
      c0 = b[pos];
      c1 = b[pos+1];
      c2 = b[pos+2];
      pos += 3;
      x = x ^ c0 ^ c1 ^ c2;
      if (c2[7:4] != 4'h0) begin
        exp_ok = 1'b0;
        exp_used = pos;
        return;
      end
      exp_addr.push_back(8'(w));
      exp_data.push_back({c2[3:0], c1, c0});
    end
    exp_used = pos + 1;
    exp_ok = (b[pos] == x);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    bit ok = 1'b0;
    logic r;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data = d;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      r = rx_ready;
      @(posedge clk);
      #1;
      if (r === 1'b1) ok = 1'b1;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept: byte %h not taken, rx_ready=%b want 1",
               d, rx_ready);
    end
  endtask

  task automatic send_frame(input bq_t b, input int cnt, input int gmax);
    for (int i = 0; i < cnt; i++)
      send_byte(b[i], $urandom_range(gmax, 0));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic clear_got();
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({rx_ready, mem_we, cpu_rst, busy, done, error} !== 6'b001000) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 001000",
               {rx_ready, mem_we, cpu_rst, busy, done, error});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_mem: got %h/%h want 0/0", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({rx_ready, cpu_rst, busy, done, error} !== 5'b01000) begin
      n_bad++;
      $display("FAIL idle_ctl: got %b want 01000",
               {rx_ready, cpu_rst, busy, done, error});
    end
  endtask

  task automatic test_normal();
    bq_t b = '{8'h02, 8'h34, 8'h12, 8'h05, 8'h78, 8'h56, 8'h0A, 8'h05};
    clear_got();
    do_start();
    n_cmp++;
    if ({busy, cpu_rst, rx_ready} !== 3'b111) begin
      n_bad++;
      $display("FAIL start_state: got %b want 111",
               {busy, cpu_rst, rx_ready});
    end
    send_frame(b, b.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (got_addr.size() != 2) begin
      n_bad++;
      $display("FAIL normal_nwr: got %0d want 2", got_addr.size());
    end else begin
      n_cmp++;
      if ({got_addr[0], got_data[0], got_addr[1], got_data[1]} !==
          {8'h00, 20'h51234, 8'h01, 20'hA5678}) begin
        n_bad++;
        $display("FAIL normal_wr: got %h:%h %h:%h want 00:51234 01:a5678",
                 got_addr[0], got_data[0], got_addr[1], got_data[1]);
      end
    end
    n_cmp++;
    if ({done, error, cpu_rst, busy} !== 4'b1000) begin
      n_bad++;
      $display("FAIL normal_st: got %b want 1000",
               {done, error, cpu_rst, busy});
    end
  endtask

  task automatic test_bad_checksum();
    bq_t b = '{8'h02, 8'h34, 8'h12, 8'h05, 8'h78, 8'h56, 8'h0A, 8'h06};
    clear_got();
    do_start();
    send_frame(b, b.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (got_data.size() != 2 ||
        {got_data[0], got_data[1]} !== {20'h51234, 20'hA5678}) begin
      n_bad++;
      $display("FAIL badck_wr: got %0d writes want 2 (51234,a5678)",
               got_data.size());
    end
    n_cmp++;
    if ({done, error, cpu_rst, busy} !== 4'b0110) begin
      n_bad++;
      $display("FAIL badck_st: got %b want 0110",
               {done, error, cpu_rst, busy});
    end
  endtask

  task automatic test_empty();
    bq_t b = '{8'h00, 8'h00};
    clear_got();
    do_start();
    send_frame(b, b.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (got_addr.size() != 0) begin
      n_bad++;
      $display("FAIL empty_nwr: got %0d want 0", got_addr.size());
    end
    n_cmp++;
    if ({done, error, cpu_rst, busy} !== 4'b1000) begin
      n_bad++;
      $display("FAIL empty_st: got %b want 1000",
               {done, error, cpu_rst, busy});
    end
  endtask

  task automatic test_reserved();
    bq_t b = '{8'h01, 8'h00, 8'h00, 8'h15};
    clear_got();
    do_start();
    send_frame(b, b.size(), 0);
    n_cmp++;
    if ({error, rx_ready, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL resv_st: got %b want 100", {error, rx_ready, busy});
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (got_addr.size() != 0 || rx_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL resv_nwr: got %0d writes rdy=%b want 0 writes rdy=0",
               got_addr.size(), rx_ready);
    end
  endtask

  task automatic test_timeout();
    clear_got();
    do_start();
    send_byte(8'h01, 0);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if ({error, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL tmo_early: got %b want 01", {error, busy});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({error, busy, cpu_rst, rx_ready} !== 4'b1010) begin
      n_bad++;
      $display("FAIL tmo_hit: got %b want 1010",
               {error, busy, cpu_rst, rx_ready});
    end
    do_start();
    send_byte(8'h01, 0);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data = 8'hAB;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    n_cmp++;
    if ({error, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL tmo_race: got %b want 01", {error, busy});
    end
    send_byte(8'hCD, 0);
    send_byte(8'h0E, 0);
    send_byte(8'h69, 0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (got_data.size() != 1 || got_data[0] !== 20'hECDAB ||
        {done, error} !== 2'b10) begin
      n_bad++;
      $display("FAIL tmo_cont: got %0d writes done/err=%b want 1 (ecdab) 10",
               got_data.size(), {done, error});
    end
  endtask

  task automatic test_start_ignored();
    bq_t b = '{8'h02, 8'h34, 8'h12, 8'h05, 8'h78, 8'h56, 8'h0A, 8'h05};
    clear_got();
    do_start();
    send_frame(b, 3, 2);
    do_start();
    for (int i = 3; i < b.size(); i++)
      send_byte(b[i], $urandom_range(3, 0));
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (got_data.size() != 2 ||
        {got_data[0], got_data[1]} !== {20'h51234, 20'hA5678} ||
        {done, error} !== 2'b10) begin
      n_bad++;
      $display("FAIL start_ign: got %0d writes done/err=%b want 2 10",
               got_data.size(), {done, error});
    end
  endtask

  task automatic test_reset_mid();
    bq_t b = '{8'h02, 8'h34, 8'h12, 8'h05, 8'h78, 8'h56, 8'h0A, 8'h05};
    clear_got();
    do_start();
    send_frame(b, 4, 0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rx_ready, mem_we, cpu_rst, busy, done, error, mem_addr,
         mem_wdata} !== {6'b001000, 28'h0}) begin
      n_bad++;
      $display("FAIL rst_mid: got %b %h %h want 001000 00 00000",
               {rx_ready, mem_we, cpu_rst, busy, done, error},
               mem_addr, mem_wdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_got();
    do_start();
    send_frame(b, b.size(), 2);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (got_data.size() != 2 ||
        {got_data[0], got_data[1]} !== {20'h51234, 20'hA5678} ||
        {done, error, cpu_rst} !== 3'b100) begin
      n_bad++;
      $display("FAIL rst_reload: got %0d writes st=%b want 2 100",
               got_data.size(), {done, error, cpu_rst});
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      bq_t b;
      int n = $urandom_range(6, 0);
      int mode = $urandom_range(3, 0);
      int bad_w = (n > 0) ? $urandom_range(n - 1, 0) : 0;
      logic [7:0] x;
      logic [19:0] wv;
      b.push_back(8'(n));
      x = 8'(n);
      for (int w = 0; w < n; w++) begin
        wv = 20'($urandom);
        b.push_back(wv[7:0]);
        b.push_back(wv[15:8]);
        if (mode == 1 && w == bad_w)
          b.push_back({4'(1 + $urandom_range(14, 0)), wv[19:16]});
        else
          b.push_back({4'h0, wv[19:16]});
        x = x ^ b[b.size()-3] ^ b[b.size()-2] ^ b[b.size()-1];
      end
      b.push_back(mode == 0 ? (x ^ 8'(1 + $urandom_range(254, 0))) : x);
      model(b);
      clear_got();
      do_start();
      send_frame(b, exp_used, 4);
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (got_addr.size() != exp_addr.size()) begin
        n_bad++;
        $display("FAIL rnd_nwr[%0d]: got %0d want %0d",
                 it, got_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          n_cmp++;
          if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) begin
            n_bad++;
            $display("FAIL rnd_wr[%0d.%0d]: got %h:%h want %h:%h", it, i,
                     got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
      n_cmp++;
      if ({done, error, cpu_rst, busy, rx_ready} !==
          {exp_ok, !exp_ok, !exp_ok, 2'b00}) begin
        n_bad++;
        $display("FAIL rnd_st[%0d]: got %b want %b", it,
                 {done, error, cpu_rst, busy, rx_ready},
                 {exp_ok, !exp_ok, !exp_ok, 2'b00});
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_checksum();
    test_empty();
    test_reserved();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
